// File: rtl/pc_next_unit_if.sv
// Bus between the core-side control logic and the program-counter stage.
// The stage takes the slave modport; the core (or a bench) takes the master modport.
interface pc_next_unit_if #(
    parameter int XLEN = 32
);
    logic            PCSrc;
    logic [XLEN-1:0] ImmExt;
    logic            stall;
    logic            imem_ready;
    logic            trap_clr;
    logic [XLEN-1:0] PC;
    logic            fetch_valid;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] PCTarget;
    logic            trap;
    logic [XLEN-1:0] trap_pc;
    logic [31:0]     retire_cnt;
    logic [1:0]      state_dbg;

    // Handshake: a fetch is accepted on a rising edge where fetch_valid & imem_ready & ~stall.
    // fetch_valid comes from registered state only and never depends on imem_ready or stall.
    modport master (
        output PCSrc, ImmExt, stall, imem_ready, trap_clr,
        input  PC, fetch_valid, PCPlus4, PCTarget, trap, trap_pc, retire_cnt, state_dbg
    );

    modport slave (
        input  PCSrc, ImmExt, stall, imem_ready, trap_clr,
        output PC, fetch_valid, PCPlus4, PCTarget, trap, trap_pc, retire_cnt, state_dbg
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter stage: holds PC, selects PC+4 or the branch target, handshakes
// with instruction memory and traps on a misaligned branch target.
module pc_next_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_next_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = (BOOT_CYCLES > 0) ? CW'(BOOT_CYCLES - 1) : '0;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [CW-1:0]   boot_cnt, boot_cnt_n;
    logic [XLEN-1:0] trap_pc, trap_pc_n;
    logic [31:0]     retire_cnt, retire_cnt_n;
    logic [XLEN-1:0] pc_plus4, pc_target;
    logic            advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            pc         <= RESET_VECTOR;
            boot_cnt   <= '0;
            trap_pc    <= '0;
            retire_cnt <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            boot_cnt   <= boot_cnt_n;
            trap_pc    <= trap_pc_n;
            retire_cnt <= retire_cnt_n;
        end
    end

    // Both adders wrap modulo 2^XLEN; overflow is intentionally not reported.
    assign pc_plus4  = pc + XLEN'(4);
    assign pc_target = pc + bus.ImmExt;
    assign advance   = (state == ST_RUN) && bus.imem_ready && !bus.stall;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        boot_cnt_n   = boot_cnt;
        trap_pc_n    = trap_pc;
        retire_cnt_n = retire_cnt;
        case (state)
            ST_BOOT: begin
                boot_cnt_n = boot_cnt + 1'b1;
                if ((BOOT_CYCLES == 0) || (boot_cnt == BOOT_LAST)) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (advance) begin
                    // The trapping advance still counts as retired.
                    retire_cnt_n = retire_cnt + 32'd1;
                    if (!bus.PCSrc) begin
                        pc_n = pc_plus4;
                    end else if (pc_target[1:0] == 2'b00) begin
                        pc_n = pc_target;
                    end else begin
                        state_n   = ST_TRAP;
                        trap_pc_n = pc_target;
                    end
                end
            end
            ST_TRAP: begin
                if (bus.trap_clr) begin
                    state_n    = ST_BOOT;
                    pc_n       = RESET_VECTOR;
                    boot_cnt_n = '0;
                end
            end
            default: begin
                state_n = ST_BOOT;
            end
        endcase
    end

    assign bus.PC          = pc;
    assign bus.PCPlus4     = pc_plus4;
    assign bus.PCTarget    = pc_target;
    assign bus.fetch_valid = (state == ST_RUN);
    assign bus.trap        = (state == ST_TRAP);
    assign bus.trap_pc     = trap_pc;
    assign bus.retire_cnt  = retire_cnt;
    assign bus.state_dbg   = state;
endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
Program-counter stage that consumes PCSrc from the branch-decision gate (zero & Branch) and produces the fetch address for instruction memory. Holds the PC register and computes PC+4 and the branch target. Selects the next PC, handshakes with instruction memory, and traps on a misaligned branch target. Sits between the branch-decision logic and the instruction memory port.

Parameters:
XLEN, 32, datapath and PC width
RESET_VECTOR, 32'h0000_0000, PC value after reset and after trap clear
BOOT_CYCLES, 2, idle cycles after reset before the first fetch is issued (0 allowed)

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous, active-low reset
PCSrc  in  1  take-branch select from the branch-decision gate
ImmExt  in  XLEN  sign-extended branch offset for the instruction at PC
stall  in  1  hazard hold; PC must not advance while high
imem_ready  in  1  instruction memory accepts the current fetch address
trap_clr  in  1  clears a trap and restarts from RESET_VECTOR
PC  out  XLEN  current fetch address
fetch_valid  out  1  PC is a valid fetch request
PCPlus4  out  XLEN  PC + 4, combinational
PCTarget  out  XLEN  PC + ImmExt, combinational
trap  out  1  misaligned-target trap active
trap_pc  out  XLEN  offending target address captured at the trap
retire_cnt  out  32  count of accepted PC advances

Behaviour:
- Reset (rst_n low, asynchronous): state=BOOT, PC=RESET_VECTOR, boot counter=0, trap=0, trap_pc=0, retire_cnt=0, fetch_valid=0.
- Arithmetic: PCPlus4 and PCTarget are modulo 2^XLEN with no overflow flag. 0xFFFF_FFFC+4 = 0x0000_0000.
- fetch_valid is registered-state-derived and equals (state==RUN). It does not depend combinationally on stall or imem_ready.
- advance = (state==RUN) & imem_ready & ~stall.
- BOOT state:
  - fetch_valid=0.
  - Boot counter increments each cycle.
  - Move to RUN on the edge where counter==BOOT_CYCLES-1.
  - If BOOT_CYCLES==0, move to RUN on the first edge after reset release.
- RUN state, on a clock edge with advance=1:
  - PCSrc=0: PC <= PCPlus4.
  - PCSrc=1 and PCTarget[1:0]==0: PC <= PCTarget.
  - PCSrc=1 and PCTarget[1:0]!=0: PC holds, state <= TRAP, trap <= 1, trap_pc <= PCTarget.
  - retire_cnt increments by 1 on every advance, including the trapping one. It wraps at 2^32.
- RUN with advance=0: PC and retire_cnt hold. PCSrc and ImmExt are ignored on that edge.
- stall has priority over imem_ready: stall=1 means no advance regardless of imem_ready.
- TRAP state:
  - fetch_valid=0, PC frozen, trap=1, trap_pc held.
  - stall, imem_ready and PCSrc are ignored.
- trap_clr:
  - Acts only in TRAP.
  - Next edge: state <= BOOT, PC <= RESET_VECTOR, boot counter <= 0, trap <= 0.
  - trap_pc and retire_cnt are retained.
  - In BOOT or RUN, trap_clr is ignored.
- Latency: a new PC is visible the cycle after the advancing edge. The single-cycle core presents PCSrc/ImmExt for the instruction at the current PC in the same cycle.
- Reset mid-operation: asynchronous rst_n low immediately forces all reset values from any state, including TRAP.

Test Plan:
- Reset release, BOOT_CYCLES=2, imem_ready=1, stall=0 -> fetch_valid=0 for 2 cycles, then 1. PC sequence 0x0, 0x4, 0x8. retire_cnt increments 1 per cycle.
- At PC=0x10 assert PCSrc=1, ImmExt=0xFFFF_FFF0 for one advancing cycle -> next PC=0x0, retire_cnt+1. PCPlus4=0x14 and PCTarget=0x0 before the edge.
- stall=1 for 3 cycles at PC=0x8, with PCSrc toggling and imem_ready=1 -> PC stays 0x8 and retire_cnt frozen. After release, PC=0xC.
- imem_ready=0 for 2 cycles at PC=0x20 -> PC holds at 0x20, fetch_valid stays 1. After ready returns, PC=0x24.
- At PC=0x30, PCSrc=1, ImmExt=0x6 -> trap=1, trap_pc=0x36, PC=0x30, fetch_valid=0. Assert trap_clr -> BOOT, PC=0x0, trap=0, trap_pc=0x36 retained, fetch resumes after 2 cycles.
- Wrap and async reset: load PC to 0xFFFF_FFFC via branch, then advance -> PC=0x0. Drop rst_n mid-cycle -> PC=RESET_VECTOR, fetch_valid=0 immediately, without waiting for a clock edge.
